// File: rtl/acia_rx.sv
// 6551-style ACIA receiver: oversampled start/data/parity/stop framing into a
// receive holding register with parity, framing and overrun status.
module acia_rx #(
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_tick,
  input  logic       rxd,
  input  logic [1:0] word_len,
  input  logic       parity_en,
  input  logic [1:0] parity_mode,
  input  logic       rd_strobe,
  output logic [7:0] data_out,
  output logic       rdrf,
  output logic       pe,
  output logic       fe,
  output logic       ovrn
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rxd_s;
  logic                   armed;
  logic [CW-1:0]          tick_cnt;
  logic [2:0]             bit_cnt;
  logic [2:0]             last_bit;
  logic                   par_en_l;
  logic [1:0]             par_mode_l;
  logic [7:0]             shift;
  logic                   par_acc;
  logic                   par_err;
  logic                   par_exp;
  logic                   load;

  assign rxd_s = sync[SYNC_STAGES-1];
  assign load  = (state == STOP) && baud_tick && (tick_cnt == FULL);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '1;
    end else begin
      sync[0] <= rxd;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
    end
  end

  always_comb begin
    par_exp = 1'b0;
    unique case (par_mode_l)
      2'b00:   par_exp = ~par_acc;
      2'b01:   par_exp = par_acc;
      2'b10:   par_exp = 1'b1;
      default: par_exp = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      armed      <= 1'b0;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      last_bit   <= '0;
      par_en_l   <= 1'b0;
      par_mode_l <= '0;
      shift      <= '0;
      par_acc    <= 1'b0;
      par_err    <= 1'b0;
      data_out   <= '0;
      rdrf       <= 1'b0;
      pe         <= 1'b0;
      fe         <= 1'b0;
      ovrn       <= 1'b0;
    end else begin
      if (baud_tick) begin
        unique case (state)
          // Falling edge is detected as "low after a tick that saw high"; armed
          // is cleared on start so a held-low break yields only one frame.
          IDLE: begin
            if (rxd_s) begin
              armed <= 1'b1;
            end else if (armed) begin
              armed      <= 1'b0;
              state      <= START;
              tick_cnt   <= '0;
              bit_cnt    <= '0;
              last_bit   <= 3'd7 - {1'b0, word_len};
              par_en_l   <= parity_en;
              par_mode_l <= parity_mode;
              shift      <= '0;
              par_acc    <= 1'b0;
              par_err    <= 1'b0;
            end
          end
          START: begin
            if (tick_cnt == HALF) begin
              tick_cnt <= '0;
              state    <= rxd_s ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          DATA: begin
            if (tick_cnt == FULL) begin
              tick_cnt       <= '0;
              shift[bit_cnt] <= rxd_s;
              par_acc        <= par_acc ^ rxd_s;
              if (bit_cnt == last_bit) state <= par_en_l ? PARITY : STOP;
              else                     bit_cnt <= bit_cnt + 1'b1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          PARITY: begin
            if (tick_cnt == FULL) begin
              tick_cnt <= '0;
              par_err  <= (rxd_s != par_exp);
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          STOP: begin
            if (tick_cnt == FULL) begin
              tick_cnt <= '0;
              state    <= IDLE;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end

      // A read in the load cycle completes first, so the new frame still lands.
      if (load) begin
        if (!rdrf || rd_strobe) begin
          data_out <= shift;
          pe       <= par_err;
          fe       <= ~rxd_s;
          rdrf     <= 1'b1;
          if (rd_strobe) ovrn <= 1'b0;
        end else begin
          ovrn <= 1'b1;
        end
      end else if (rd_strobe) begin
        rdrf <= 1'b0;
        ovrn <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_acia_rx.sv
// Bench for acia_rx: frame-level scoreboard checked every cycle plus
// hand-computed expectations for each directed scenario.
module tb_acia_rx;

  logic       clk = 1'b0;
  logic       reset, baud_tick, rxd, parity_en, rd_strobe;
  logic [1:0] word_len, parity_mode;
  logic [7:0] data_out;
  logic       rdrf, pe, fe, ovrn;

  int checks = 0;
  int errors = 0;
  int tick_no = 0;

  typedef struct {
    int         tick;
    logic [7:0] data;
    logic       pe;
    logic       fe;
  } frame_t;

  frame_t     q[$];
  logic [7:0] m_data;
  logic       m_rdrf, m_pe, m_fe, m_ovrn;

  acia_rx #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .rxd(rxd),
    .word_len(word_len), .parity_en(parity_en), .parity_mode(parity_mode),
    .rd_strobe(rd_strobe), .data_out(data_out), .rdrf(rdrf), .pe(pe),
    .fe(fe), .ovrn(ovrn)
  );

  always #5 clk = ~clk;

  // One baud tick every 4 clocks.
  initial begin : tick_gen
    int div;
    div = 0;
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      baud_tick = (div == 3);
      div = (div + 1) % 4;
    end
  end

  // Scoreboard: each queued frame is delivered at its mid-stop tick.
  initial begin : model
    frame_t f;
    logic   ld;
    m_data = '0; m_rdrf = 1'b0; m_pe = 1'b0; m_fe = 1'b0; m_ovrn = 1'b0;
    forever begin
      @(posedge clk);
      if (baud_tick) tick_no++;
      ld = baud_tick && (q.size() > 0) && (q[0].tick == tick_no);
      if (reset) begin
        m_data = '0; m_rdrf = 1'b0; m_pe = 1'b0; m_fe = 1'b0; m_ovrn = 1'b0;
        q.delete();
      end else if (ld) begin
        f = q.pop_front();
        if (!m_rdrf || rd_strobe) begin
          m_data = f.data; m_pe = f.pe; m_fe = f.fe; m_rdrf = 1'b1;
          if (rd_strobe) m_ovrn = 1'b0;
        end else begin
          m_ovrn = 1'b1;
        end
      end else if (rd_strobe) begin
        m_rdrf = 1'b0;
        m_ovrn = 1'b0;
      end
    end
  end

  initial begin : compare
    @(posedge clk);
    forever begin
      @(negedge clk);
      checks++;
      if ({data_out, rdrf, pe, fe, ovrn} !== {m_data, m_rdrf, m_pe, m_fe, m_ovrn}) begin
        errors++;
        $display("FAIL cycle_compare t=%0t: got data=%h rdrf=%b pe=%b fe=%b ovrn=%b, want data=%h rdrf=%b pe=%b fe=%b ovrn=%b",
                 $time, data_out, rdrf, pe, fe, ovrn, m_data, m_rdrf, m_pe, m_fe, m_ovrn);
      end
    end
  end

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic wait_tick();
    do @(posedge clk); while (baud_tick !== 1'b1);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) wait_tick();
  endtask

  task automatic do_read();
    @(posedge clk); #2 rd_strobe = 1'b1;
    @(posedge clk); #2 rd_strobe = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] data, input int n, input logic pen,
                            input logic [1:0] mode, input int par_force, input logic stop,
                            input logic rd_on_load, input logic scramble);
    logic [7:0] d;
    logic       good, sent;
    int         t0, nb;
    frame_t     f;
    d = data & (8'hFF >> (8 - n));
    case (mode)
      2'b00:   good = ~^d;
      2'b01:   good = ^d;
      2'b10:   good = 1'b1;
      default: good = 1'b0;
    endcase
    sent = (par_force < 0) ? good : par_force[0];
    wait_tick();
    word_len = 2'(8 - n); parity_en = pen; parity_mode = mode;
    rxd = 1'b0;
    t0 = tick_no;
    nb = 1 + n + (pen ? 1 : 0);
    f.tick = t0 + 1 + 16 * nb + 8;
    f.data = d;
    f.pe   = pen && (sent != good);
    f.fe   = ~stop;
    q.push_back(f);
    for (int k = 0; k < 16; k++) begin
      wait_tick();
      if (k == 0 && scramble) begin
        word_len = ~word_len; parity_en = ~parity_en; parity_mode = ~parity_mode;
      end
    end
    for (int i = 0; i < n; i++) begin
      rxd = d[i];
      idle(16);
    end
    if (pen) begin
      rxd = sent;
      idle(16);
    end
    rxd = stop;
    for (int k = 0; k < 16; k++) begin
      if (rd_on_load && tick_no == f.tick - 1) begin
        repeat (3) @(posedge clk);
        #2 rd_strobe = 1'b1;
        @(posedge clk);
        #2 rd_strobe = 1'b0;
      end
      wait_tick();
    end
  endtask

  initial begin : stim
    reset = 1'b1; rxd = 1'b1; rd_strobe = 1'b0;
    word_len = 2'b00; parity_en = 1'b0; parity_mode = 2'b00;
    repeat (4) @(posedge clk);
    #2;
    check("reset_data", data_out, 8'h00);
    check("reset_rdrf", {7'd0, rdrf}, 8'h00);
    check("reset_flags", {5'd0, pe, fe, ovrn}, 8'h00);
    reset = 1'b0;
    idle(4);

    send_frame(8'hA5, 8, 1'b0, 2'b00, -1, 1'b1, 1'b0, 1'b0);
    check("a5_data", data_out, 8'hA5);
    check("a5_rdrf", {7'd0, rdrf}, 8'h01);
    check("a5_pe_fe", {6'd0, pe, fe}, 8'h00);
    do_read();
    check("a5_read_rdrf", {7'd0, rdrf}, 8'h00);
    check("a5_read_hold", data_out, 8'hA5);
    idle(4);

    send_frame(8'h41, 7, 1'b1, 2'b01, 1, 1'b1, 1'b0, 1'b0);
    check("7e1_data", data_out, 8'h41);
    check("7e1_pe_fe", {6'd0, pe, fe}, 8'h02);
    do_read();
    check("7e1_read_rdrf_pe", {6'd0, rdrf, pe}, 8'h01);
    idle(4);

    send_frame(8'h3C, 8, 1'b0, 2'b00, -1, 1'b0, 1'b0, 1'b0);
    idle(48);
    check("brk_data", data_out, 8'h3C);
    check("brk_rdrf_fe_ovrn", {5'd0, rdrf, fe, ovrn}, 8'h06);
    rxd = 1'b1;
    idle(20);
    do_read();
    check("brk_read_rdrf", {7'd0, rdrf}, 8'h00);

    send_frame(8'h11, 8, 1'b0, 2'b00, -1, 1'b1, 1'b0, 1'b0);
    idle(2);
    send_frame(8'h22, 8, 1'b0, 2'b00, -1, 1'b1, 1'b0, 1'b0);
    check("ovr_data", data_out, 8'h11);
    check("ovr_rdrf_ovrn", {6'd0, rdrf, ovrn}, 8'h03);
    do_read();
    check("ovr_read", {6'd0, rdrf, ovrn}, 8'h00);
    idle(4);

    send_frame(8'h66, 8, 1'b0, 2'b00, -1, 1'b1, 1'b0, 1'b0);
    idle(2);
    send_frame(8'h77, 8, 1'b0, 2'b00, -1, 1'b1, 1'b1, 1'b0);
    check("rdload_data", data_out, 8'h77);
    check("rdload_rdrf_ovrn", {6'd0, rdrf, ovrn}, 8'h02);
    do_read();
    idle(4);

    send_frame(8'h07, 8, 1'b1, 2'b00, -1, 1'b1, 1'b0, 1'b0);
    check("8o1_data_pe", {data_out}, 8'h07);
    check("8o1_pe", {7'd0, pe}, 8'h00);
    do_read();
    send_frame(8'h2A, 6, 1'b1, 2'b10, 0, 1'b1, 1'b0, 1'b0);
    check("6m1_data", data_out, 8'h2A);
    check("6m1_pe", {7'd0, pe}, 8'h01);
    do_read();
    idle(4);

    wait_tick();
    rxd = 1'b0;
    idle(4);
    rxd = 1'b1;
    idle(24);
    check("glitch_rdrf", {7'd0, rdrf}, 8'h00);
    send_frame(8'h1F, 5, 1'b0, 2'b00, -1, 1'b1, 1'b0, 1'b1);
    check("5n1_data", data_out, 8'h1F);
    check("5n1_rdrf_pe", {6'd0, rdrf, pe}, 8'h02);
    idle(4);

    wait_tick();
    word_len = 2'b00; parity_en = 1'b0; parity_mode = 2'b00;
    rxd = 1'b0;
    idle(16);
    rxd = 1'b0; idle(16);
    rxd = 1'b1; idle(16);
    rxd = 1'b0; idle(16);
    rxd = 1'b1; idle(8);
    @(posedge clk);
    #2 reset = 1'b1;
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("midrst_data", data_out, 8'h00);
    check("midrst_flags", {4'd0, rdrf, pe, fe, ovrn}, 8'h00);
    reset = 1'b0;
    idle(4);
    send_frame(8'h5A, 8, 1'b0, 2'b00, -1, 1'b1, 1'b0, 1'b0);
    check("post_rst_data", data_out, 8'h5A);
    check("post_rst_rdrf", {7'd0, rdrf}, 8'h01);
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
